// File: rtl/dma_burst_seq.sv
`default_nettype none
// ============================================================================
// Module      : dma_burst_seq
// Description : DMA burst sequencer. Accepts one DMA request, splits it into
//               ATA commands of at most MAX_SECT sectors and, for each
//               command, issues four 128-byte memory burst requests per
//               sector while keeping no more than MAX_OUTST bursts in flight.
// Ports       : sclk/rst_n       clock, asynchronous active-low reset
//               i_dma_*          request from the register block
//               o_dma_done/err   completion pulse and abort status
//               o_busy           transfer in progress
//               o_cmd_* i_cmd_*  ATA command back-end handshake
//               o_burst_*        memory burst request (valid/ready)
//               i_burst_ack      one accepted burst has completed
// Revision    : 1.0 - initial release
// ============================================================================
module dma_burst_seq #(
  parameter int MAX_SECT  = 256,
  parameter int MAX_OUTST = 2
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        i_dma_start,
  input  logic [24:0] i_mem_address,
  input  logic [31:0] i_lba,
  input  logic [31:0] i_sector_cnt,
  input  logic        i_dma_type,
  output logic        o_dma_done,
  output logic        o_dma_err,
  output logic        o_busy,
  output logic        o_cmd_val,
  input  logic        i_cmd_rdy,
  output logic [31:0] o_cmd_lba,
  output logic [15:0] o_cmd_count,
  output logic        o_cmd_write,
  input  logic        i_cmd_done,
  input  logic        i_cmd_err,
  output logic        o_burst_val,
  input  logic        i_burst_rdy,
  output logic [24:0] o_burst_addr,
  input  logic        i_burst_ack
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_CMD   = 3'd1;
  localparam logic [2:0] c_BURST = 3'd2;
  localparam logic [2:0] c_WAIT  = 3'd3;
  localparam logic [2:0] c_ABORT = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;

  localparam logic [31:0] c_MAX_SECT  = 32'(MAX_SECT);
  localparam logic [3:0]  c_MAX_OUTST = 4'(MAX_OUTST);

  logic [2:0]  r_state;
  logic [24:0] r_addr;
  logic [31:0] r_lba;
  logic [31:0] r_remain;
  logic        r_write;
  // Sized for 4 * 65535 bursts so the largest legal chunk never truncates.
  logic [17:0] r_bursts_left;
  logic [3:0]  r_outst;
  logic        r_done_seen;
  logic        r_err;

  logic [15:0] w_chunk;
  logic        w_cmd_fire;
  logic        w_burst_fire;
  logic        w_ack_take;
  logic        w_wait_exit;
  logic        w_err_take;
  logic        w_done_window;

  // The chunk is derived from the remaining count, which only changes when
  // leaving WAIT, so it is stable for the whole CMD/BURST/WAIT sequence.
  assign w_chunk = (r_remain < c_MAX_SECT) ? r_remain[15:0] : c_MAX_SECT[15:0];

  assign o_cmd_val    = (r_state == c_CMD);
  assign o_cmd_lba    = r_lba;
  assign o_cmd_count  = w_chunk;
  assign o_cmd_write  = r_write;
  assign o_burst_val  = (r_state == c_BURST) && (r_bursts_left != 18'd0) &&
                        (r_outst < c_MAX_OUTST);
  assign o_burst_addr = r_addr;
  assign o_busy       = (r_state != c_IDLE) && (r_state != c_DONE);
  assign o_dma_done   = (r_state == c_DONE);
  assign o_dma_err    = (r_state == c_DONE) && r_err;

  assign w_cmd_fire    = o_cmd_val & i_cmd_rdy;
  assign w_burst_fire  = o_burst_val & i_burst_rdy;
  // An acknowledge with nothing in flight is dropped so the count cannot wrap.
  assign w_ack_take    = i_burst_ack & (r_outst != 4'd0);
  assign w_wait_exit   = (r_state == c_WAIT) & (r_done_seen | i_cmd_done);
  assign w_done_window = (r_state == c_CMD) || (r_state == c_BURST) || (r_state == c_WAIT);
  assign w_err_take    = i_cmd_err & w_done_window;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_IDLE;
      r_addr        <= 25'd0;
      r_lba         <= 32'd0;
      r_remain      <= 32'd0;
      r_write       <= 1'b0;
      r_bursts_left <= 18'd0;
      r_outst       <= 4'd0;
      r_done_seen   <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      // Accept and acknowledge in the same cycle cancel out.
      if (w_burst_fire && !w_ack_take) begin
        r_outst <= r_outst + 4'd1;
      end else if (!w_burst_fire && w_ack_take) begin
        r_outst <= r_outst - 4'd1;
      end

      if (w_burst_fire) begin
        r_addr        <= r_addr + 25'd1;
        r_bursts_left <= r_bursts_left - 18'd1;
      end

      // Device completion may arrive before the bursts drain; remember it.
      if (i_cmd_done && w_done_window) begin
        r_done_seen <= 1'b1;
      end

      case (r_state)
        c_IDLE: begin
          if (i_dma_start) begin
            r_addr   <= i_mem_address;
            r_lba    <= i_lba;
            r_remain <= i_sector_cnt;
            r_write  <= i_dma_type;
            r_err    <= 1'b0;
            // A zero-length request passes through WAIT with completion
            // already flagged, so it finishes without issuing a command.
            r_done_seen <= (i_sector_cnt == 32'd0);
            r_state     <= (i_sector_cnt == 32'd0) ? c_WAIT : c_CMD;
          end
        end
        c_CMD: begin
          if (w_err_take) begin
            r_err   <= 1'b1;
            r_state <= c_ABORT;
          end else if (w_cmd_fire) begin
            r_bursts_left <= {w_chunk, 2'b00};
            r_state       <= c_BURST;
          end
        end
        c_BURST: begin
          if (w_err_take) begin
            r_err   <= 1'b1;
            r_state <= c_ABORT;
          end else if ((r_bursts_left == 18'd0) && (r_outst == 4'd0)) begin
            r_state <= c_WAIT;
          end
        end
        c_WAIT: begin
          if (w_err_take) begin
            r_err   <= 1'b1;
            r_state <= c_ABORT;
          end else if (w_wait_exit) begin
            r_lba       <= r_lba + {16'd0, w_chunk};
            r_remain    <= r_remain - {16'd0, w_chunk};
            r_done_seen <= 1'b0;
            r_state     <= (r_remain == {16'd0, w_chunk}) ? c_DONE : c_CMD;
          end
        end
        c_ABORT: begin
          // Bursts already handed out must be acknowledged before finishing.
          if (r_outst == 4'd0) begin
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_burst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_burst_seq
// Description : Self-checking bench for dma_burst_seq. Expected commands and
//               burst addresses are queued when a request is issued and are
//               compared against what the sequencer actually hands out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_burst_seq;

  localparam int MAX_SECT  = 256;
  localparam int MAX_OUTST = 2;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_dma_start = 1'b0;
  logic [24:0] i_mem_address = '0;
  logic [31:0] i_lba = '0;
  logic [31:0] i_sector_cnt = '0;
  logic        i_dma_type = 1'b0;
  logic        o_dma_done, o_dma_err, o_busy, o_cmd_val, o_cmd_write, o_burst_val;
  logic        i_cmd_rdy = 1'b0, i_cmd_done = 1'b0, i_cmd_err = 1'b0;
  logic        i_burst_rdy = 1'b0, i_burst_ack = 1'b0;
  logic [31:0] o_cmd_lba;
  logic [15:0] o_cmd_count;
  logic [24:0] o_burst_addr;

  always #5 sclk = ~sclk;

  dma_burst_seq #(.MAX_SECT(MAX_SECT), .MAX_OUTST(MAX_OUTST)) u_dut (
    .sclk(sclk), .rst_n(rst_n),
    .i_dma_start(i_dma_start), .i_mem_address(i_mem_address), .i_lba(i_lba),
    .i_sector_cnt(i_sector_cnt), .i_dma_type(i_dma_type),
    .o_dma_done(o_dma_done), .o_dma_err(o_dma_err), .o_busy(o_busy),
    .o_cmd_val(o_cmd_val), .i_cmd_rdy(i_cmd_rdy), .o_cmd_lba(o_cmd_lba),
    .o_cmd_count(o_cmd_count), .o_cmd_write(o_cmd_write),
    .i_cmd_done(i_cmd_done), .i_cmd_err(i_cmd_err),
    .o_burst_val(o_burst_val), .i_burst_rdy(i_burst_rdy),
    .o_burst_addr(o_burst_addr), .i_burst_ack(i_burst_ack)
  );

  typedef struct packed { logic [31:0] lba; logic [15:0] cnt; logic w; } cmd_t;

  cmd_t        exp_cmd[$], obs_cmd[$];
  logic [24:0] exp_burst[$], obs_burst[$];
  int          ack_due[$];

  int checks = 0, errors = 0, cyc = 0;
  int ack_delay = 2, done_delay = 0;
  int outst_m, max_outst, full_viol, same_cyc, proto_bad, saw_cmd_val, saw_burst_val;
  int bursts_for_cmd, acks_for_cmd, done_at, accepted, err_after, ign_after;
  int done_cyc, start_cyc, first_cmd_cyc, outst_at_done, outst_at_err;
  bit cmd_active, err_fired, ign_fired, in_xfer, done_seen, start_req;
  logic        done_err;
  logic [24:0] s_addr;
  logic [31:0] s_lba, s_cnt;
  logic        s_type;

  task automatic clear_model();
    exp_cmd.delete(); obs_cmd.delete(); exp_burst.delete(); obs_burst.delete(); ack_due.delete();
    outst_m = 0; max_outst = 0; full_viol = 0; same_cyc = 0; proto_bad = 0;
    saw_cmd_val = 0; saw_burst_val = 0; bursts_for_cmd = 0; acks_for_cmd = 0;
    done_at = -1; accepted = 0; err_after = 0; ign_after = 0;
    cmd_active = 0; err_fired = 0; ign_fired = 0; in_xfer = 0; done_seen = 0; start_req = 0;
    done_err = 1'b0; done_cyc = -1; start_cyc = -1; first_cmd_cyc = -1;
    outst_at_done = -1; outst_at_err = -1;
  endtask

  // Reference split of a request into commands and burst addresses.
  task automatic push_expected(logic [24:0] a, logic [31:0] l, logic [31:0] n, logic w);
    logic [31:0] rem, ch, lb;
    logic [24:0] aa;
    rem = n; lb = l; aa = a;
    while (rem != 0) begin
      ch = (rem > 32'(MAX_SECT)) ? 32'(MAX_SECT) : rem;
      exp_cmd.push_back({lb, ch[15:0], w});
      for (int i = 0; i < int'(ch) * 4; i++) begin
        exp_burst.push_back(aa);
        aa = aa + 25'd1;
      end
      lb  = lb + ch;
      rem = rem - ch;
    end
  endtask

  // One clock of back-end behaviour: observe at the falling edge, drive the
  // responses for the next rising edge, then drop all pulses.
  task automatic cycle();
    bit fire, ack, err_now;
    @(negedge sclk);
    if (o_dma_done) begin
      if (!in_xfer || o_busy) proto_bad++;
      done_seen = 1; done_err = o_dma_err; done_cyc = cyc; outst_at_done = outst_m; in_xfer = 0;
    end else if (o_busy !== in_xfer) begin
      proto_bad++;
    end
    if (o_cmd_val) saw_cmd_val++;
    if (o_burst_val) saw_burst_val++;
    if (o_burst_val && outst_m >= MAX_OUTST) full_viol++;
    if (o_cmd_val && first_cmd_cyc < 0) first_cmd_cyc = cyc;

    i_dma_start = 1'b0;
    if (start_req) begin
      i_dma_start = 1'b1; i_mem_address = s_addr; i_lba = s_lba;
      i_sector_cnt = s_cnt; i_dma_type = s_type;
      start_cyc = cyc; in_xfer = 1; start_req = 0;
    end else if (ign_after > 0 && !ign_fired && accepted >= ign_after) begin
      ign_fired = 1; i_dma_start = 1'b1; i_mem_address = 25'h1234;
      i_lba = 32'hDEAD; i_sector_cnt = 32'd9; i_dma_type = ~i_dma_type;
    end

    err_now = (err_after > 0) && !err_fired && (accepted >= err_after);
    i_cmd_err = err_now;
    if (err_now) begin
      err_fired = 1; cmd_active = 0; done_at = -1; outst_at_err = outst_m;
    end

    i_cmd_rdy = o_cmd_val && !err_now && ($urandom_range(0, 2) != 0);
    if (o_cmd_val && i_cmd_rdy) begin
      obs_cmd.push_back({o_cmd_lba, o_cmd_count, o_cmd_write});
      bursts_for_cmd = 4 * int'(o_cmd_count); acks_for_cmd = 0; cmd_active = 1;
    end

    i_burst_rdy = !err_now && !err_fired;
    fire = o_burst_val && i_burst_rdy;
    if (fire) begin
      obs_burst.push_back(o_burst_addr);
      ack_due.push_back(cyc + ack_delay);
      accepted++;
    end
    ack = (ack_due.size() > 0) && (ack_due[0] <= cyc);
    i_burst_ack = ack;
    if (ack) begin
      void'(ack_due.pop_front());
      acks_for_cmd++;
    end
    if (fire && ack) same_cyc++;
    outst_m = outst_m + (fire ? 1 : 0) - (ack ? 1 : 0);
    if (outst_m > max_outst) max_outst = outst_m;

    i_cmd_done = 1'b0;
    if (cmd_active && done_at < 0 && acks_for_cmd == bursts_for_cmd) done_at = cyc + done_delay;
    if (done_at >= 0 && cyc >= done_at) begin
      i_cmd_done = 1'b1; done_at = -1; cmd_active = 0;
    end

    @(posedge sclk);
    cyc++;
    #1;
    i_dma_start = 1'b0; i_cmd_err = 1'b0; i_cmd_done = 1'b0;
    i_burst_ack = 1'b0; i_cmd_rdy = 1'b0; i_burst_rdy = 1'b0;
  endtask

  task automatic start_xfer(logic [24:0] a, logic [31:0] l, logic [31:0] n, logic w);
    s_addr = a; s_lba = l; s_cnt = n; s_type = w; start_req = 1;
    push_expected(a, l, n, w);
    cycle();
  endtask

  task automatic run_until_done(int bound);
    for (int k = 0; k < bound && !done_seen; k++) cycle();
  endtask

  task automatic test_reset();
    logic [78:0] outs;
    clear_model();
    #1;
    outs = {o_dma_done, o_dma_err, o_busy, o_cmd_val, o_cmd_lba, o_cmd_count,
            o_cmd_write, o_burst_val, o_burst_addr};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h, expected 0", outs); end
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    repeat (3) cycle();
    checks++;
    if (o_busy !== 1'b0 || o_cmd_val !== 1'b0 || proto_bad != 0) begin
      errors++; $display("FAIL reset_idle: busy=%b cmd_val=%b proto=%0d, expected 0 0 0", o_busy, o_cmd_val, proto_bad);
    end
  endtask

  task automatic test_single();
    cmd_t oc, ec; logic [24:0] ob, eb;
    clear_model(); ack_delay = 3; done_delay = 0;
    start_xfer(25'h100, 32'h10, 32'd1, 1'b1);
    run_until_done(500);
    checks++; if (!done_seen) begin errors++; $display("FAIL single_done: no dma_done in 500 cycles"); end
    checks++; if (first_cmd_cyc != start_cyc + 1) begin errors++; $display("FAIL single_cmd_latency: got %0d, expected %0d", first_cmd_cyc - start_cyc, 1); end
    checks++; if (obs_cmd.size() != 1) begin errors++; $display("FAIL single_cmd_count: got %0d, expected 1", obs_cmd.size()); end
    while (obs_cmd.size() > 0 && exp_cmd.size() > 0) begin
      oc = obs_cmd.pop_front(); ec = exp_cmd.pop_front(); checks++;
      if (oc !== ec) begin errors++; $display("FAIL single_cmd: got %h/%0d/%b, expected %h/%0d/%b", oc.lba, oc.cnt, oc.w, ec.lba, ec.cnt, ec.w); end
    end
    checks++; if (obs_burst.size() != 4) begin errors++; $display("FAIL single_burst_count: got %0d, expected 4", obs_burst.size()); end
    while (obs_burst.size() > 0 && exp_burst.size() > 0) begin
      ob = obs_burst.pop_front(); eb = exp_burst.pop_front(); checks++;
      if (ob !== eb) begin errors++; $display("FAIL single_burst_addr: got %h, expected %h", ob, eb); end
    end
    checks++; if (done_err !== 1'b0 || proto_bad != 0) begin errors++; $display("FAIL single_status: err=%b proto=%0d, expected 0 0", done_err, proto_bad); end
  endtask

  task automatic test_multi();
    cmd_t oc, ec; logic [24:0] ob, eb; int bad;
    clear_model(); ack_delay = 2; done_delay = 3;
    start_xfer(25'h5000, 32'h0, 32'd600, 1'b0);
    run_until_done(20000);
    checks++; if (!done_seen) begin errors++; $display("FAIL multi_done: no dma_done in 20000 cycles"); end
    checks++; if (obs_cmd.size() != 3) begin errors++; $display("FAIL multi_cmd_count: got %0d, expected 3", obs_cmd.size()); end
    while (obs_cmd.size() > 0 && exp_cmd.size() > 0) begin
      oc = obs_cmd.pop_front(); ec = exp_cmd.pop_front(); checks++;
      if (oc !== ec) begin errors++; $display("FAIL multi_cmd: got %h/%0d/%b, expected %h/%0d/%b", oc.lba, oc.cnt, oc.w, ec.lba, ec.cnt, ec.w); end
    end
    checks++; if (obs_burst.size() != 2400) begin errors++; $display("FAIL multi_burst_count: got %0d, expected 2400", obs_burst.size()); end
    bad = 0;
    while (obs_burst.size() > 0 && exp_burst.size() > 0) begin
      ob = obs_burst.pop_front(); eb = exp_burst.pop_front(); checks++;
      if (ob !== eb && bad < 8) begin errors++; bad++; $display("FAIL multi_burst_addr: got %h, expected %h", ob, eb); end
      else if (ob !== eb) errors++;
    end
    checks++; if (done_err !== 1'b0 || proto_bad != 0) begin errors++; $display("FAIL multi_status: err=%b proto=%0d, expected 0 0", done_err, proto_bad); end
  endtask

  task automatic test_outstanding();
    logic [24:0] ob, eb;
    clear_model(); ack_delay = 10; done_delay = 0;
    start_xfer(25'h800, 32'h20, 32'd2, 1'b1);
    run_until_done(2000);
    checks++; if (!done_seen) begin errors++; $display("FAIL outst_done: no dma_done in 2000 cycles"); end
    checks++; if (max_outst != MAX_OUTST) begin errors++; $display("FAIL outst_max: got %0d, expected %0d", max_outst, MAX_OUTST); end
    checks++; if (full_viol != 0) begin errors++; $display("FAIL outst_val_when_full: got %0d cycles, expected 0", full_viol); end
    checks++; if (same_cyc == 0) begin errors++; $display("FAIL outst_same_cycle: got %0d, expected >0", same_cyc); end
    checks++; if (obs_burst.size() != 8) begin errors++; $display("FAIL outst_burst_count: got %0d, expected 8", obs_burst.size()); end
    while (obs_burst.size() > 0 && exp_burst.size() > 0) begin
      ob = obs_burst.pop_front(); eb = exp_burst.pop_front(); checks++;
      if (ob !== eb) begin errors++; $display("FAIL outst_burst_addr: got %h, expected %h", ob, eb); end
    end
    checks++; if (done_err !== 1'b0 || proto_bad != 0) begin errors++; $display("FAIL outst_status: err=%b proto=%0d, expected 0 0", done_err, proto_bad); end
  endtask

  task automatic test_zero();
    clear_model(); ack_delay = 2; done_delay = 0;
    start_xfer(25'h10, 32'h5, 32'd0, 1'b1);
    run_until_done(50);
    checks++; if (!done_seen) begin errors++; $display("FAIL zero_done: no dma_done in 50 cycles"); end
    checks++; if (done_cyc - start_cyc != 2) begin errors++; $display("FAIL zero_latency: got %0d, expected 2", done_cyc - start_cyc); end
    checks++; if (saw_cmd_val != 0 || saw_burst_val != 0) begin errors++; $display("FAIL zero_no_traffic: cmd_val=%0d burst_val=%0d cycles, expected 0 0", saw_cmd_val, saw_burst_val); end
    checks++; if (done_err !== 1'b0 || proto_bad != 0) begin errors++; $display("FAIL zero_status: err=%b proto=%0d, expected 0 0", done_err, proto_bad); end
  endtask

  task automatic test_abort();
    cmd_t oc, ec; logic [24:0] ob, eb;
    clear_model(); ack_delay = 10; done_delay = 0; err_after = 5; ign_after = 1;
    start_xfer(25'h40, 32'h99, 32'd2, 1'b0);
    run_until_done(1000);
    checks++; if (!done_seen) begin errors++; $display("FAIL abort_done: no dma_done in 1000 cycles"); end
    checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL abort_err: got %b, expected 1", done_err); end
    checks++; if (obs_burst.size() != 5) begin errors++; $display("FAIL abort_burst_count: got %0d, expected 5", obs_burst.size()); end
    while (obs_burst.size() > 0 && exp_burst.size() > 0) begin
      ob = obs_burst.pop_front(); eb = exp_burst.pop_front(); checks++;
      if (ob !== eb) begin errors++; $display("FAIL abort_burst_addr: got %h, expected %h", ob, eb); end
    end
    checks++; if (obs_cmd.size() != 1) begin errors++; $display("FAIL abort_cmd_count: got %0d, expected 1", obs_cmd.size()); end
    if (obs_cmd.size() > 0) begin
      oc = obs_cmd.pop_front(); ec = exp_cmd.pop_front(); checks++;
      if (oc !== ec) begin errors++; $display("FAIL abort_cmd: got %h/%0d/%b, expected %h/%0d/%b", oc.lba, oc.cnt, oc.w, ec.lba, ec.cnt, ec.w); end
    end
    checks++; if (outst_at_err < 1 || outst_at_done != 0) begin errors++; $display("FAIL abort_drain: in flight at err=%0d at done=%0d, expected >=1 and 0", outst_at_err, outst_at_done); end
    checks++; if (proto_bad != 0) begin errors++; $display("FAIL abort_busy: got %0d protocol errors, expected 0", proto_bad); end
  endtask

  task automatic test_wrap();
    logic [24:0] ob, eb;
    clear_model(); ack_delay = 1; done_delay = 0;
    start_xfer(25'h1FFFFFF, 32'h77, 32'd1, 1'b1);
    run_until_done(500);
    checks++; if (!done_seen) begin errors++; $display("FAIL wrap_done: no dma_done in 500 cycles"); end
    checks++; if (obs_burst.size() != 4) begin errors++; $display("FAIL wrap_burst_count: got %0d, expected 4", obs_burst.size()); end
    while (obs_burst.size() > 0 && exp_burst.size() > 0) begin
      ob = obs_burst.pop_front(); eb = exp_burst.pop_front(); checks++;
      if (ob !== eb) begin errors++; $display("FAIL wrap_burst_addr: got %h, expected %h", ob, eb); end
    end
  endtask

  task automatic test_reset_mid();
    logic [78:0] outs; cmd_t oc, ec; logic [24:0] ob, eb;
    clear_model(); ack_delay = 4; done_delay = 0;
    start_xfer(25'h200, 32'h40, 32'd4, 1'b0);
    for (int k = 0; k < 200 && accepted < 3; k++) cycle();
    checks++; if (accepted < 3) begin errors++; $display("FAIL rstmid_progress: got %0d bursts, expected >=3", accepted); end
    #2 rst_n = 1'b0;
    #1;
    outs = {o_dma_done, o_dma_err, o_busy, o_cmd_val, o_cmd_lba, o_cmd_count,
            o_cmd_write, o_burst_val, o_burst_addr};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL rstmid_outputs: got %h, expected 0", outs); end
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    clear_model();
    start_xfer(25'h300, 32'h7, 32'd2, 1'b1);
    run_until_done(1000);
    checks++; if (!done_seen) begin errors++; $display("FAIL rstmid_done: no dma_done in 1000 cycles"); end
    checks++; if (obs_cmd.size() != 1) begin errors++; $display("FAIL rstmid_cmd_count: got %0d, expected 1", obs_cmd.size()); end
    while (obs_cmd.size() > 0 && exp_cmd.size() > 0) begin
      oc = obs_cmd.pop_front(); ec = exp_cmd.pop_front(); checks++;
      if (oc !== ec) begin errors++; $display("FAIL rstmid_cmd: got %h/%0d/%b, expected %h/%0d/%b", oc.lba, oc.cnt, oc.w, ec.lba, ec.cnt, ec.w); end
    end
    checks++; if (obs_burst.size() != 8) begin errors++; $display("FAIL rstmid_burst_count: got %0d, expected 8", obs_burst.size()); end
    while (obs_burst.size() > 0 && exp_burst.size() > 0) begin
      ob = obs_burst.pop_front(); eb = exp_burst.pop_front(); checks++;
      if (ob !== eb) begin errors++; $display("FAIL rstmid_burst_addr: got %h, expected %h", ob, eb); end
    end
    checks++; if (done_err !== 1'b0 || proto_bad != 0) begin errors++; $display("FAIL rstmid_status: err=%b proto=%0d, expected 0 0", done_err, proto_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_outstanding();
    test_zero();
    test_abort();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
